axi_err_responder: RTL and testbench



---
 rtl/axi_err_responder.sv | 186 ++++++++++++++++++
 tb/tb_axi_err_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_err_responder.sv
// AXI4 subordinate that answers every write and read burst with an error response.
// Write and read sides run independent single-outstanding FSMs; completions are counted.
module axi_err_responder #(
  parameter int          ID_WIDTH   = 4,
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 128,
  parameter logic [1:0]  ERR_RESP   = 2'b10,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     s_AWID,
  input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
  input  logic [7:0]              s_AWLEN,
  input  logic [2:0]              s_AWSIZE,
  input  logic [1:0]              s_AWBURST,
  input  logic                    s_AWLOCK,
  input  logic [3:0]              s_AWCACHE,
  input  logic [2:0]              s_AWPROT,
  input  logic                    s_AWVALID,
  output logic                    s_AWREADY,
  input  logic [DATA_WIDTH-1:0]   s_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
  input  logic                    s_WLAST,
  input  logic                    s_WVALID,
  output logic                    s_WREADY,
  output logic [ID_WIDTH-1:0]     s_BID,
  output logic [1:0]              s_BRESP,
  output logic                    s_BVALID,
  input  logic                    s_BREADY,
  input  logic [ID_WIDTH-1:0]     s_ARID,
  input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
  input  logic [7:0]              s_ARLEN,
  input  logic [2:0]              s_ARSIZE,
  input  logic [1:0]              s_ARBURST,
  input  logic                    s_ARLOCK,
  input  logic [3:0]              s_ARCACHE,
  input  logic [2:0]              s_ARPROT,
  input  logic                    s_ARVALID,
  output logic                    s_ARREADY,
  output logic [ID_WIDTH-1:0]     s_RID,
  output logic [DATA_WIDTH-1:0]   s_RDATA,
  output logic [1:0]              s_RRESP,
  output logic                    s_RLAST,
  output logic                    s_RVALID,
  input  logic                    s_RREADY,
  output logic [CNT_WIDTH-1:0]    wr_err_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_err_cnt_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  wr_state_e             wr_state_r, wr_state_s;
  rd_state_e             rd_state_r, rd_state_s;
  logic [ID_WIDTH-1:0]   wr_id_r;
  logic [ID_WIDTH-1:0]   rd_id_r;
  logic [7:0]            rd_len_r;
  logic [7:0]            rd_beat_r;
  logic [CNT_WIDTH-1:0]  wr_cnt_r;
  logic [CNT_WIDTH-1:0]  rd_cnt_r;
  logic                  aw_hs_s, w_last_hs_s, b_hs_s, ar_hs_s, r_hs_s, r_last_s;
  logic                  unused_s;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1'b1);
    end
  endfunction

  // Address, size, burst and write payload are accepted but never used.
  assign unused_s = ^{s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST, s_AWLOCK, s_AWCACHE, s_AWPROT,
                      s_WDATA, s_WSTRB, s_ARADDR, s_ARSIZE, s_ARBURST, s_ARLOCK, s_ARCACHE,
                      s_ARPROT};

  assign s_AWREADY    = (wr_state_r == W_IDLE);
  assign s_WREADY     = (wr_state_r == W_DATA);
  assign s_BVALID     = (wr_state_r == W_RESP);
  assign s_BID        = wr_id_r;
  assign s_BRESP      = ERR_RESP;
  assign s_ARREADY    = (rd_state_r == R_IDLE);
  assign s_RVALID     = (rd_state_r == R_DATA);
  assign s_RID        = rd_id_r;
  assign s_RDATA      = {DATA_WIDTH{1'b0}};
  assign s_RRESP      = ERR_RESP;
  assign r_last_s     = (rd_state_r == R_DATA) && (rd_beat_r == rd_len_r);
  assign s_RLAST      = r_last_s;
  assign wr_err_cnt_o = wr_cnt_r;
  assign rd_err_cnt_o = rd_cnt_r;
  assign busy_o       = (wr_state_r != W_IDLE) || (rd_state_r != R_IDLE);

  assign aw_hs_s     = s_AWVALID & s_AWREADY;
  assign w_last_hs_s = s_WVALID & s_WREADY & s_WLAST;
  assign b_hs_s      = s_BVALID & s_BREADY;
  assign ar_hs_s     = s_ARVALID & s_ARREADY;
  assign r_hs_s      = s_RVALID & s_RREADY;

  // State registers for both FSMs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
    end
  end

  // Write FSM next state: AWLEN is ignored, only WLAST closes the burst.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (aw_hs_s) wr_state_s = W_DATA;
        else         wr_state_s = W_IDLE;
      end
      W_DATA: begin
        if (w_last_hs_s) wr_state_s = W_RESP;
        else             wr_state_s = W_DATA;
      end
      W_RESP: begin
        if (b_hs_s) wr_state_s = W_IDLE;
        else        wr_state_s = W_RESP;
      end
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (ar_hs_s) rd_state_s = R_DATA;
        else         rd_state_s = R_IDLE;
      end
      R_DATA: begin
        if (r_hs_s && r_last_s) rd_state_s = R_IDLE;
        else                    rd_state_s = R_DATA;
      end
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Captured request fields, read beat tracking and completion counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_id_r   <= {ID_WIDTH{1'b0}};
      rd_id_r   <= {ID_WIDTH{1'b0}};
      rd_len_r  <= 8'd0;
      rd_beat_r <= 8'd0;
      wr_cnt_r  <= {CNT_WIDTH{1'b0}};
      rd_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (aw_hs_s) begin
        wr_id_r <= s_AWID;
      end
      if (b_hs_s) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
      if (ar_hs_s) begin
        rd_id_r   <= s_ARID;
        rd_len_r  <= s_ARLEN;
        rd_beat_r <= 8'd0;
      end else if (r_hs_s) begin
        rd_beat_r <= rd_beat_r + 8'd1;
      end
      if (r_hs_s && r_last_s) begin
        rd_cnt_r <= sat_inc(rd_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_axi_err_responder.sv
// Self-checking bench for axi_err_responder: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of outstanding bursts.
module tb_axi_err_responder;

  localparam int IDW  = 4;
  localparam int AW   = 64;
  localparam int DW   = 128;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic [IDW-1:0]  s_AWID = '0, s_ARID = '0, s_BID, s_RID;
  logic [AW-1:0]   s_AWADDR = '0, s_ARADDR = '0;
  logic [7:0]      s_AWLEN = '0, s_ARLEN = '0;
  logic [2:0]      s_AWSIZE = '0, s_AWPROT = '0, s_ARSIZE = '0, s_ARPROT = '0;
  logic [1:0]      s_AWBURST = '0, s_ARBURST = '0, s_BRESP, s_RRESP;
  logic            s_AWLOCK = 1'b0, s_ARLOCK = 1'b0;
  logic [3:0]      s_AWCACHE = '0, s_ARCACHE = '0;
  logic            s_AWVALID = 1'b0, s_AWREADY, s_WLAST = 1'b0, s_WVALID = 1'b0, s_WREADY;
  logic [DW-1:0]   s_WDATA = '0, s_RDATA;
  logic [DW/8-1:0] s_WSTRB = '0;
  logic            s_BVALID, s_BREADY = 1'b0, s_ARVALID = 1'b0, s_ARREADY;
  logic            s_RLAST, s_RVALID, s_RREADY = 1'b0;
  logic [CW-1:0]   wr_err_cnt_o, rd_err_cnt_o;
  logic            busy_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Transaction-level model: is a burst open, has its data ended, beats still owed.
  bit             m_wr_open = 1'b0, m_wr_last = 1'b0, m_rd_open = 1'b0;
  logic [IDW-1:0] m_wr_id = '0, m_rd_id = '0;
  int             m_rd_left = 0, m_wr_done = 0, m_rd_done = 0, r_beats = 0;

  axi_err_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .ERR_RESP(2'b10), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWBURST(s_AWBURST), .s_AWLOCK(s_AWLOCK), .s_AWCACHE(s_AWCACHE), .s_AWPROT(s_AWPROT),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID),
    .s_WREADY(s_WREADY),
    .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_ARLOCK(s_ARLOCK), .s_ARCACHE(s_ARCACHE), .s_ARPROT(s_ARPROT),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .wr_err_cnt_o(wr_err_cnt_o), .rd_err_cnt_o(rd_err_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Per-cycle comparison against the model, then model update from the handshakes.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_wr_open <= 1'b0; m_wr_last <= 1'b0; m_rd_open <= 1'b0;
      m_rd_left <= 0; m_wr_done <= 0; m_rd_done <= 0;
      check_eq("rst_awready", s_AWREADY, 1'b1);
      check_eq("rst_arready", s_ARREADY, 1'b1);
      check_eq("rst_wready", s_WREADY, 1'b0);
      check_eq("rst_bvalid", s_BVALID, 1'b0);
      check_eq("rst_rvalid", s_RVALID, 1'b0);
      check_eq("rst_rlast", s_RLAST, 1'b0);
      check_eq("rst_ids", {s_BID, s_RID}, '0);
      check_eq("rst_rdata", s_RDATA, '0);
      check_eq("rst_resp", {s_BRESP, s_RRESP}, 4'b1010);
      check_eq("rst_cnts", {wr_err_cnt_o, rd_err_cnt_o}, '0);
      check_eq("rst_busy", busy_o, 1'b0);
    end else begin
      check_eq("awready", s_AWREADY, !m_wr_open);
      check_eq("wready", s_WREADY, m_wr_open && !m_wr_last);
      check_eq("bvalid", s_BVALID, m_wr_open && m_wr_last);
      if (m_wr_open && m_wr_last) begin
        check_eq("bid", s_BID, m_wr_id);
        check_eq("bresp", s_BRESP, 2'b10);
      end
      check_eq("arready", s_ARREADY, !m_rd_open);
      check_eq("rvalid", s_RVALID, m_rd_open);
      check_eq("rlast", s_RLAST, m_rd_open && (m_rd_left == 1));
      if (m_rd_open) begin
        check_eq("rid", s_RID, m_rd_id);
        check_eq("rdata", s_RDATA, '0);
        check_eq("rresp", s_RRESP, 2'b10);
      end
      check_eq("wr_cnt", wr_err_cnt_o, sat(m_wr_done));
      check_eq("rd_cnt", rd_err_cnt_o, sat(m_rd_done));
      check_eq("busy", busy_o, m_wr_open || m_rd_open);
      if (s_AWVALID && !m_wr_open) begin
        m_wr_open <= 1'b1; m_wr_last <= 1'b0; m_wr_id <= s_AWID;
      end else if (s_WVALID && s_WLAST && m_wr_open && !m_wr_last) begin
        m_wr_last <= 1'b1;
      end else if (s_BREADY && m_wr_open && m_wr_last) begin
        m_wr_open <= 1'b0; m_wr_done <= m_wr_done + 1;
      end
      if (s_ARVALID && !m_rd_open) begin
        m_rd_open <= 1'b1; m_rd_left <= int'(s_ARLEN) + 1; m_rd_id <= s_ARID;
      end else if (s_RREADY && m_rd_open) begin
        r_beats <= r_beats + 1;
        m_rd_left <= m_rd_left - 1;
        if (m_rd_left == 1) begin
          m_rd_open <= 1'b0; m_rd_done <= m_rd_done + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic aw_send(input logic [IDW-1:0] id, input logic [7:0] len);
    s_AWVALID = 1'b1; s_AWID = id; s_AWLEN = len;
    for (int i = 0; i < 50 && !s_AWREADY; i++) step();
    check_eq("aw_accept", s_AWREADY, 1'b1);
    step();
    s_AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [IDW-1:0] id, input logic [7:0] len);
    s_ARVALID = 1'b1; s_ARID = id; s_ARLEN = len;
    for (int i = 0; i < 50 && !s_ARREADY; i++) step();
    check_eq("ar_accept", s_ARREADY, 1'b1);
    step();
    s_ARVALID = 1'b0;
  endtask

  task automatic w_send(input int n);
    s_WVALID = 1'b1;
    for (int b = 0; b < n; b++) begin
      s_WLAST = (b == n - 1);
      s_WDATA = {4{$urandom}};
      for (int i = 0; i < 50 && !s_WREADY; i++) step();
      check_eq("w_accept", s_WREADY, 1'b1);
      step();
    end
    s_WVALID = 1'b0; s_WLAST = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 700 && busy_o; i++) step();
    check_eq("idle_reached", busy_o, 1'b0);
  endtask

  initial begin
    int base;
    #1 rst_ni = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    step();

    // Single-beat write, BREADY held high.
    s_BREADY = 1'b1;
    aw_send(4'h3, 8'd0);
    w_send(1);
    wait_idle();
    check_eq("wr1_cnt", wr_err_cnt_o, 4'd1);

    // 8-beat read with RREADY toggling.
    base = r_beats;
    ar_send(4'hA, 8'd7);
    for (int i = 0; i < 40 && s_RVALID; i++) begin
      s_RREADY = (i % 2 == 0);
      step();
    end
    s_RREADY = 1'b0;
    check_eq("rd8_beats", r_beats - base, 8);
    check_eq("rd8_cnt", rd_err_cnt_o, 4'd1);

    // W presented before AW is held off until the write address is taken.
    s_WVALID = 1'b1; s_WLAST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("w_early", s_WREADY, 1'b0);
      step();
    end
    aw_send(4'h5, 8'd3);
    w_send(4);
    wait_idle();
    check_eq("wr4_cnt", wr_err_cnt_o, 4'd2);

    // Concurrent AW and a 256-beat AR.
    do_reset();
    s_RREADY = 1'b1;
    base = r_beats;
    s_AWVALID = 1'b1; s_AWID = 4'h1; s_AWLEN = 8'd1;
    s_ARVALID = 1'b1; s_ARID = 4'h2; s_ARLEN = 8'd255;
    check_eq("cc_ready", {s_AWREADY, s_ARREADY}, 2'b11);
    step();
    s_AWVALID = 1'b0; s_ARVALID = 1'b0;
    w_send(2);
    wait_idle();
    check_eq("cc_beats", r_beats - base, 256);
    check_eq("cc_cnts", {wr_err_cnt_o, rd_err_cnt_o}, {4'd1, 4'd1});

    // Reset in the middle of a 16-beat read.
    do_reset();
    base = r_beats;
    ar_send(4'h6, 8'd15);
    repeat (5) step();
    check_eq("mid_beats", r_beats - base, 5);
    s_RREADY = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rvalid", s_RVALID, 1'b0);
    check_eq("mid_cnts", {wr_err_cnt_o, rd_err_cnt_o, busy_o}, '0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    s_RREADY = 1'b1;
    base = r_beats;
    ar_send(4'h9, 8'd0);
    wait_idle();
    check_eq("post_beats", r_beats - base, 1);
    check_eq("post_cnt", rd_err_cnt_o, 4'd1);

    // Random traffic; enough completions to drive both counters into saturation.
    for (int c = 0; c < 4000; c++) begin
      s_AWVALID = 1'($urandom_range(0, 1));
      s_AWID    = 4'($urandom);
      s_AWLEN   = 8'($urandom);
      s_AWADDR  = {$urandom, $urandom};
      s_WVALID  = 1'($urandom_range(0, 1));
      s_WLAST   = ($urandom_range(0, 3) == 0);
      s_WDATA   = {4{$urandom}};
      s_BREADY  = 1'($urandom_range(0, 1));
      s_ARVALID = 1'($urandom_range(0, 1));
      s_ARID    = 4'($urandom);
      s_ARLEN   = 8'($urandom_range(0, 5));
      s_RREADY  = 1'($urandom_range(0, 1));
      step();
    end
    s_AWVALID = 1'b0; s_ARVALID = 1'b0;
    s_WVALID = 1'b1; s_WLAST = 1'b1; s_BREADY = 1'b1; s_RREADY = 1'b1;
    wait_idle();
    check_eq("wr_sat", wr_err_cnt_o, 4'hF);
    check_eq("rd_sat", rd_err_cnt_o, 4'hF);
    s_WVALID = 1'b0; s_WLAST = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
